// File: rtl/subpixel_row_scheduler_pkg.sv
// Shared types and constants for the subpixel row scheduler.
package subpixel_row_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_DONE,
        OUTPUT
    } state_e;

    localparam int unsigned ROWS_DEF    = 15;
    localparam int unsigned ROW_PIX_DEF = 15;
    localparam int unsigned FILT_MARGIN = 3;

endpackage

// File: rtl/subpixel_rd_pipe.sv
// Valid shift register tracking in-flight row reads across the memory latency.
module subpixel_rd_pipe #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic clr_i,
    input  logic en_i,
    output logic vld_o,
    output logic pend_c_o
);

    logic [MEM_LAT-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= en_i;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Reads still travelling toward the output stage.
    always_comb begin
        pend_c_o = 1'b0;
        for (int unsigned i = 0; i + 1 < MEM_LAT; i++) begin
            pend_c_o = pend_c_o | vld_q[i];
        end
    end

    assign vld_o = vld_q[MEM_LAT-1];

endmodule

// File: rtl/subpixel_row_scheduler.sv
// Fetches the reference rows of one 8x8 block, streams them to the interpolator
// and hands a tagged completion downstream once the interpolator finishes.
module subpixel_row_scheduler
    import subpixel_row_scheduler_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned ROW_PIX = ROW_PIX_DEF,
    parameter int unsigned ROWS    = ROWS_DEF,
    parameter int unsigned FRAME_H = 64,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [COORD_W-1:0]         req_x,
    input  logic [COORD_W-1:0]         req_y,
    output logic                       mem_rd_en,
    output logic [COORD_W-1:0]         mem_rd_row,
    output logic [COORD_W:0]           mem_rd_col,
    input  logic [PIX_W*ROW_PIX-1:0]   mem_rd_data,
    output logic                       interp_start,
    output logic [PIX_W*ROW_PIX-1:0]   interp_row,
    output logic                       interp_row_vld,
    input  logic                       interp_done,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic [COORD_W-1:0]         blk_x,
    output logic [COORD_W-1:0]         blk_y,
    output logic                       err,
    output logic [15:0]                blk_count
);

    localparam int unsigned K_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned S_W  = COORD_W + 2;

    state_e              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [COORD_W-1:0]  mem_rd_row_q, mem_rd_row_d;
    logic [COORD_W:0]    mem_rd_col_q, mem_rd_col_d;
    logic                interp_start_q, interp_start_d;
    logic                blk_valid_q, blk_valid_d;
    logic                pend_c;

    // Row index y-3+k, clamped into the frame; negative results wrap to a set MSB.
    function automatic logic [COORD_W-1:0] clamp_row(input logic [COORD_W-1:0] y,
                                                     input logic [K_W-1:0] k);
        logic [S_W-1:0] r;
        r = S_W'(y) + S_W'(k) - S_W'(FILT_MARGIN);
        if (r[S_W-1])
            return '0;
        else if (r > S_W'(FRAME_H - 1))
            return COORD_W'(FRAME_H - 1);
        else
            return r[COORD_W-1:0];
    endfunction

    subpixel_rd_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .clr_i    (rst),
        .en_i     (mem_rd_en_q),
        .vld_o    (interp_row_vld),
        .pend_c_o (pend_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            x_q            <= '0;
            y_q            <= '0;
            k_q            <= '0;
            to_q           <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            req_ready_q    <= 1'b1;
            mem_rd_en_q    <= 1'b0;
            mem_rd_row_q   <= '0;
            mem_rd_col_q   <= '0;
            interp_start_q <= 1'b0;
            blk_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            k_q            <= k_d;
            to_q           <= to_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            req_ready_q    <= req_ready_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_rd_row_q   <= mem_rd_row_d;
            mem_rd_col_q   <= mem_rd_col_d;
            interp_start_q <= interp_start_d;
            blk_valid_q    <= blk_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    x_d     = req_x;
                    y_d     = req_y;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (k_q == K_W'(ROWS - 1))
                    state_d = DRAIN;
                else
                    k_d = k_q + K_W'(1);
            end
            DRAIN: begin
                if (!pend_c) begin
                    to_d    = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (interp_done) begin
                    state_d = OUTPUT;
                end else if (to_q >= TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            OUTPUT: begin
                if (blk_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        req_ready_d    = (state_d == IDLE);
        mem_rd_en_d    = (state_d == FETCH);
        interp_start_d = (state_d == FETCH) && (state_q == IDLE);
        blk_valid_d    = (state_d == OUTPUT);
        mem_rd_row_d   = (state_d == FETCH) ? clamp_row(y_d, k_d) : '0;
        mem_rd_col_d   = (state_d == FETCH) ?
                         ((COORD_W+1)'(x_d) - (COORD_W+1)'(FILT_MARGIN)) : '0;
    end

    assign req_ready    = req_ready_q;
    assign mem_rd_en    = mem_rd_en_q;
    assign mem_rd_row   = mem_rd_row_q;
    assign mem_rd_col   = mem_rd_col_q;
    assign interp_start = interp_start_q;
    assign interp_row   = mem_rd_data;
    assign blk_valid    = blk_valid_q;
    assign blk_x        = x_q;
    assign blk_y        = y_q;
    assign err          = err_q;
    assign blk_count    = cnt_q;

endmodule
